wave_loader: RTL and testbench
==============================

Name: wave_loader

Overview:
- Writer-side companion to the waveform NCO: takes a byte stream (valid/ready, e.g. from a UART receiver) and drives the NCO's table-write interface (we, data, freq_step).
- Runs its own strobe counter, reset-aligned with the NCO's, so exactly one byte is presented per strobe slot while the NCO address advances by 1.
- Holds the NCO frequency step at 0 until the table is fully loaded, then releases the run-time step.

Parameters:
- P_STROBE_MAX, 520, strobe period minus 1; must equal the NCO's value.
- N_SAMPLES, 6000, number of table bytes to load (addresses 0..N_SAMPLES-1).
- CNT_W, $clog2(N_SAMPLES+1), width of the slot counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  begin load; honoured only in IDLE
- s_valid_i  in  1  stream byte valid
- s_data_i  in  8  stream byte
- s_ready_o  out  1  staging register can accept a byte
- run_step_i  in  8  frequency step to use after load
- we_o  out  1  to NCO we_i
- data_o  out  8  to NCO data_i
- freq_step_o  out  8  to NCO freq_step_i
- busy_o  out  1  state is PRIME or LOAD
- done_o  out  1  one-cycle pulse on load completion
- underrun_o  out  1  sticky: a slot had no fresh byte

Behaviour:
- Reset (async, rst_n low): state=IDLE; strobe cnt=0; stage empty; slot cnt=0. Outputs: we_o=0, data_o=0, freq_step_o=0, s_ready_o=0, busy_o=0, done_o=0, underrun_o=0.
- Strobe: cnt counts 0..P_STROBE_MAX; ce=(cnt==P_STROBE_MAX); cnt returns to 0 on the clock after ce. Period is P_STROBE_MAX+1 clocks, identical to the NCO's.
- Staging: 1-byte register. s_ready_o=busy_o && !stage_full. A byte is accepted when s_valid_i && s_ready_o, and stage_full is set next edge. No accept happens on a drain cycle (ready is low while full).
- IDLE: freq_step_o=0. start_i -> PRIME. IDLE is reached only from reset (NCO address is 0 only then).
- PRIME: wait for ce with stage_full. On that edge: data_o<=stage, stage emptied, we_o<=1, slot cnt<=0, go to LOAD. A ce with the stage empty is skipped (no slot consumed).
- LOAD: on each ce the current slot completes.
  - If slot cnt==N_SAMPLES-1: we_o<=0; go to DONE; done_o=1 for one cycle.
  - Otherwise slot cnt++. If stage_full: data_o<=stage and empty the stage. If empty: data_o holds, underrun_o<=1 (sticky), slot still consumed.
- Alignment: data_o changes on the same edge the NCO address increments, so each address sees a single stable byte for its whole slot.
- DONE: terminal until reset; we_o=0; freq_step_o=run_step_i (combinational pass-through); start_i and s_valid_i are ignored; s_ready_o=0.
- freq_step_o is 0 in IDLE, PRIME and LOAD. This keeps the NCO address frozen at 0 before the load and stepping by 1 during it.
- start_i outside IDLE: ignored.
- Reset mid-LOAD: immediate return to reset values. The partial table stays in NCO RAM; a reload starts again at address 0 because the NCO resets too.

Decomposition:
- Package wave_pkg: state enum {IDLE, PRIME, LOAD, DONE}; default constants STROBE_MAX=520 and TABLE_LEN=6000, shared with the NCO.
- Sub-module strobe_gen (parameter P_STROBE_MAX; outputs ce). Both this block and the NCO should use it so the two strobes are identical by construction.

Test Plan (P_STROBE_MAX=3, N_SAMPLES=4, NCO instantiated with same params):
- start_i, then stream 0x11,0x22,0x33,0x44 back-to-back -> NCO RAM[0..3]=11,22,33,44; done_o pulses once, 16 clocks after the first LOAD ce; we_o low afterwards; freq_step_o=run_step_i.
- Hold s_valid_i low before the first ce, present the byte 2 strobes later -> stays in PRIME, no write, NCO address remains 0, underrun_o=0.
- Withhold the 3rd byte for one slot -> RAM[2]=0x22 (repeat), underrun_o=1 and sticky, remaining bytes shift by one address, done after 4 slots.
- Pulse start_i during LOAD and in DONE -> no state change, slot cnt unaffected.
- Assert rst_n low mid-LOAD at slot 2 -> all outputs return to reset values within the same cycle; a new start_i reloads from address 0.
- Before start_i, drive run_step_i=5 -> freq_step_o=0 and NCO address stays 0 until done_o; after done, address advances by 5 per strobe.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform loader and the NCO it feeds.
// Holds the loader state encoding and the default strobe/table constants,
// which both blocks must agree on so their strobes and address ranges line up.
package wave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int STROBE_MAX = 520;   // strobe period minus 1
    localparam int TABLE_LEN  = 6000;  // waveform table length in bytes

endpackage

// File: rtl/strobe_gen.sv
// Free-running strobe generator.
// A counter runs 0..P_STROBE_MAX and ce is high while it sits at
// P_STROBE_MAX, so ce pulses once every P_STROBE_MAX+1 clocks. The loader
// and the NCO both instantiate this block so their strobes match exactly
// after a common reset.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset (counter to 0)
//   ce    - one-cycle strobe
import wave_pkg::*;

module strobe_gen #(
    parameter int P_STROBE_MAX = STROBE_MAX
) (
    input  logic clk,
    input  logic rst_n,
    output logic ce
);

    localparam int W = (P_STROBE_MAX < 1) ? 1 : $clog2(P_STROBE_MAX + 1);

    logic [W-1:0] cnt;

    assign ce = (cnt == W'(P_STROBE_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ce) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wave_loader.sv
// Waveform table loader: moves a byte stream into the NCO table-write port.
// One byte is presented per strobe slot while the NCO address steps by 1;
// the frequency step is held at 0 until the whole table is written, then
// the run-time step is passed through.
//
// Stream handshake: a byte transfers on a rising clock edge where both
// s_valid_i and s_ready_o are high. s_ready_o depends only on registered
// state, never on s_valid_i.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start_i      - begin a load (only acted on in IDLE)
//   s_valid_i, s_data_i, s_ready_o - byte stream input
//   run_step_i   - NCO step used once loading is complete
//   we_o, data_o, freq_step_o      - NCO table-write interface
//   busy_o       - loading in progress (PRIME or LOAD)
//   done_o       - one-cycle pulse when the last slot completes
//   underrun_o   - sticky flag: some slot had no fresh byte
//   state_o      - current FSM state, for observation
import wave_pkg::*;

module wave_loader #(
    parameter int P_STROBE_MAX = STROBE_MAX,
    parameter int N_SAMPLES    = TABLE_LEN,
    parameter int CNT_W        = $clog2(N_SAMPLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       s_valid_i,
    input  logic [7:0] s_data_i,
    output logic       s_ready_o,
    input  logic [7:0] run_step_i,
    output logic       we_o,
    output logic [7:0] data_o,
    output logic [7:0] freq_step_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       underrun_o,
    output state_e     state_o
);

    logic             ce;
    state_e           state;
    state_e           state_nxt;
    logic [7:0]       stage;
    logic             stage_full;
    logic [CNT_W-1:0] slot_cnt;
    logic             last_slot;
    logic             prime_fire;
    logic             slot_end;
    logic             accept;
    logic             drain;

    strobe_gen #(.P_STROBE_MAX(P_STROBE_MAX)) u_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce)
    );

    assign last_slot   = (slot_cnt == CNT_W'(N_SAMPLES - 1));
    assign busy_o      = (state == PRIME) || (state == LOAD);
    assign s_ready_o   = busy_o && !stage_full;
    assign accept      = s_valid_i && s_ready_o;
    // Stage empties at the first slot and at every later slot boundary that
    // has a byte waiting; the final boundary ends the load instead.
    assign drain       = prime_fire || (slot_end && !last_slot && stage_full);
    // Step stays 0 until loaded: the NCO address is then driven only by we_o.
    assign freq_step_o = (state == DONE) ? run_step_i : 8'h00;
    assign state_o     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        prime_fire = 1'b0;
        slot_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_nxt = PRIME;
            end
            PRIME: begin
                // A strobe with nothing staged is skipped, not consumed.
                if (ce && stage_full) begin
                    prime_fire = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                if (ce) begin
                    slot_end = 1'b1;
                    if (last_slot) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage      <= 8'h00;
            stage_full <= 1'b0;
            slot_cnt   <= '0;
            we_o       <= 1'b0;
            data_o     <= 8'h00;
            done_o     <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            done_o <= slot_end && last_slot;

            // Ready is low while full, so accept and drain never coincide.
            if (drain) begin
                data_o     <= stage;
                stage_full <= 1'b0;
            end else if (accept) begin
                stage      <= s_data_i;
                stage_full <= 1'b1;
            end

            if (prime_fire) begin
                we_o     <= 1'b1;
                slot_cnt <= '0;
            end

            if (slot_end) begin
                if (last_slot) begin
                    we_o <= 1'b0;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                    // Slot still advances; data_o repeats the previous byte.
                    if (!stage_full) underrun_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wave_loader.sv
// Directed bench for wave_loader with a small NCO write-side model.
import wave_pkg::*;

module tb_wave_loader;

    localparam int PMAX = 3;
    localparam int NS   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       s_valid_i = 1'b0;
    logic [7:0] s_data_i = 8'h00;
    logic       s_ready_o;
    logic [7:0] run_step_i = 8'h00;
    logic       we_o;
    logic [7:0] data_o;
    logic [7:0] freq_step_o;
    logic       busy_o;
    logic       done_o;
    logic       underrun_o;
    state_e     state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wave_loader #(.P_STROBE_MAX(PMAX), .N_SAMPLES(NS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_ready_o   (s_ready_o),
        .run_step_i  (run_step_i),
        .we_o        (we_o),
        .data_o      (data_o),
        .freq_step_o (freq_step_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .underrun_o  (underrun_o),
        .state_o     (state_o)
    );

    // NCO write side: address steps by 1 per strobe while we is high,
    // otherwise by freq_step; table RAM is not cleared by reset.
    logic        nco_ce;
    logic [15:0] nco_addr;
    logic [7:0]  ram [16];

    strobe_gen #(.P_STROBE_MAX(PMAX)) u_nco_strobe (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (nco_ce)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) nco_addr <= 16'd0;
        else if (nco_ce) nco_addr <= we_o ? nco_addr + 16'd1 : nco_addr + 16'(freq_step_o);
    end

    always @(posedge clk) begin
        if (we_o) ram[nco_addr[3:0]] <= data_o;
    end

    // Event monitor, sampled 1 time unit after each rising edge.
    int          cyc = 0;
    int          we_rise_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    logic [15:0] done_addr = 16'd0;
    logic        we_q = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (we_o && !we_q) we_rise_cyc = cyc;
        we_q = we_o;
        if (done_o) begin
            done_cnt++;
            done_cyc  = cyc;
            done_addr = nco_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Called at a negedge; holds the byte until a ready edge takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_valid_i = 1'b1;
        s_data_i  = b;
        while (!s_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(s_ready_o), 32'd1);
        @(negedge clk);
        s_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int snap);
        int n;
        n = 0;
        while (done_cnt == snap && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_cnt - snap), 32'd1);
        idle_cycles(2);
    endtask

    task automatic wait_addr(input logic [15:0] a);
        int n;
        n = 0;
        while (nco_addr != a && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("addr_reached", 32'(nco_addr), 32'(a));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},       32'(we_o),        32'd0);
        check({tag, "_data"},     32'(data_o),      32'd0);
        check({tag, "_freq"},     32'(freq_step_o), 32'd0);
        check({tag, "_ready"},    32'(s_ready_o),   32'd0);
        check({tag, "_busy"},     32'(busy_o),      32'd0);
        check({tag, "_done"},     32'(done_o),      32'd0);
        check({tag, "_underrun"}, 32'(underrun_o),  32'd0);
    endtask

    initial begin
        int          snap;
        logic [15:0] a0;

        // Reset state, with a run step already applied.
        run_step_i = 8'd5;
        idle_cycles(3);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle_cycles(6);
        check("idle_state", 32'(state_o), 32'(IDLE));
        check("idle_freq",  32'(freq_step_o), 32'd0);
        check("idle_addr",  32'(nco_addr), 32'd0);

        // Start with no byte for several strobes: stays in PRIME.
        pulse_start();
        idle_cycles(10);
        check("prime_state",    32'(state_o), 32'(PRIME));
        check("prime_we",       32'(we_o), 32'd0);
        check("prime_addr",     32'(nco_addr), 32'd0);
        check("prime_underrun", 32'(underrun_o), 32'd0);
        check("prime_ready",    32'(s_ready_o), 32'd1);
        check("prime_busy",     32'(busy_o), 32'd1);

        // Full load, with a stray start during LOAD.
        snap = done_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        pulse_start();
        check("load_start_ignored", 32'(state_o), 32'(LOAD));
        check("load_freq", 32'(freq_step_o), 32'd0);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_done(snap);
        check("done_latency", 32'(done_cyc - we_rise_cyc), 32'd16);
        check("done_addr", 32'(done_addr), 32'd4);
        check("ram0", 32'(ram[0]), 32'h11);
        check("ram1", 32'(ram[1]), 32'h22);
        check("ram2", 32'(ram[2]), 32'h33);
        check("ram3", 32'(ram[3]), 32'h44);
        check("done_we", 32'(we_o), 32'd0);
        check("done_freq", 32'(freq_step_o), 32'd5);
        check("done_underrun", 32'(underrun_o), 32'd0);
        check("done_state", 32'(state_o), 32'(DONE));
        check("done_pulse_low", 32'(done_o), 32'd0);
        pulse_start();
        check("done_start_ignored", 32'(state_o), 32'(DONE));
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_ready", 32'(s_ready_o), 32'd0);
        a0 = nco_addr;
        idle_cycles(12);
        check("run_step_advance", 32'(nco_addr - a0), 32'd15);
        check("done_single_pulse", 32'(done_cnt - snap), 32'd1);

        // Underrun: third byte withheld for one slot.
        do_reset();
        snap = done_cnt;
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        wait_addr(16'd2);
        idle_cycles(1);
        check("ur_flag", 32'(underrun_o), 32'd1);
        check("ur_data_repeat", 32'(data_o), 32'h22);
        send_byte(8'h33);
        wait_done(snap);
        check("ur_ram0", 32'(ram[0]), 32'h11);
        check("ur_ram1", 32'(ram[1]), 32'h22);
        check("ur_ram2", 32'(ram[2]), 32'h22);
        check("ur_ram3", 32'(ram[3]), 32'h33);
        check("ur_sticky", 32'(underrun_o), 32'd1);
        check("ur_state", 32'(state_o), 32'(DONE));
        check("ur_latency", 32'(done_cyc - we_rise_cyc), 32'd16);

        // Reset in the middle of LOAD, then reload from address 0.
        do_reset();
        pulse_start();
        send_byte(8'hA1);
        send_byte(8'hA2);
        send_byte(8'hA3);
        wait_addr(16'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        check("midrst_addr", 32'(nco_addr), 32'd0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        check("midrst_state", 32'(state_o), 32'(IDLE));
        snap = done_cnt;
        pulse_start();
        send_byte(8'hB1);
        send_byte(8'hB2);
        send_byte(8'hB3);
        send_byte(8'hB4);
        wait_done(snap);
        check("reload_ram0", 32'(ram[0]), 32'hB1);
        check("reload_ram1", 32'(ram[1]), 32'hB2);
        check("reload_ram2", 32'(ram[2]), 32'hB3);
        check("reload_ram3", 32'(ram[3]), 32'hB4);
        check("reload_underrun", 32'(underrun_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
